// File: rtl/enc_pkg.sv
// Shared types and helpers for the registered request encoder family.
// Holds the arbitration state enum and a wide one-hot decoder.
package enc_pkg;

    localparam int ENC_MAX_N = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } enc_state_e;

    // Callers narrow the result with a size cast to their own N.
    function automatic logic [ENC_MAX_N-1:0] onehot(input int idx);
        logic [ENC_MAX_N-1:0] v;
        v = ENC_MAX_N'(1) << idx;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular picker: first set bit of vec_i at or after start_i,
// wrapping N-1 -> 0. Flags whether any other bit is also set.
module rr_pick
    import enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    output logic         found_o,
    output logic [W-1:0] idx_o,
    output logic         multi_o
);

    logic [N-1:0] w_rest;

    // Smallest circular distance from start wins.
    always_comb begin
        int d;
        int best;
        d     = 0;
        best  = N;
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            d = (i >= int'(start_i)) ? i - int'(start_i) : i + N - int'(start_i);
            if (vec_i[i] && (d < best)) begin
                best  = d;
                idx_o = W'(i);
            end
        end
        found_o = (best < N);
    end

    assign w_rest  = vec_i & ~N'(onehot(int'(idx_o)));
    assign multi_o = found_o && (|w_rest);

endmodule

// File: rtl/req_priority_encoder.sv
// Registered request encoder: latches request pulses into a pending set and
// hands out one eligible index at a time on a valid/ready port.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | nothing held; out_valid low, waiting for an eligible request
//   ST_HOLD | out_idx/out_multi held stable until the consumer accepts
module req_priority_encoder
    import enc_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int RR_MODE = 0,
    localparam int W       = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] mask_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_multi,
    output logic [N-1:0] pending_o
);

    enc_state_e   r_state;
    enc_state_e   w_state_nxt;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_idx;
    logic         r_multi;
    logic [W-1:0] r_ptr;

    logic         w_accept;
    logic [N-1:0] w_held_oh;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_elig;
    logic [N-1:0] w_elig_acc;
    logic [W-1:0] w_ptr_nxt;
    logic [W-1:0] w_start_idle;
    logic [W-1:0] w_start_acc;
    logic         w_idle_found;
    logic [W-1:0] w_idle_idx;
    logic         w_idle_multi;
    logic         w_acc_found;
    logic [W-1:0] w_acc_idx;
    logic         w_acc_multi;
    logic [W-1:0] w_idx_nxt;
    logic         w_multi_nxt;

    assign w_accept   = (r_state == ST_HOLD) && out_ready;
    assign w_held_oh  = N'(onehot(int'(r_idx)));
    assign w_clr      = w_accept ? w_held_oh : '0;
    assign w_elig     = r_pending & ~mask_i;
    assign w_elig_acc = w_elig & ~w_held_oh;
    assign w_ptr_nxt  = (int'(r_idx) == N - 1) ? '0 : r_idx + W'(1);

    // The post-accept pick must already see the advanced pointer.
    assign w_start_idle = (RR_MODE != 0) ? r_ptr     : '0;
    assign w_start_acc  = (RR_MODE != 0) ? w_ptr_nxt : '0;

    rr_pick #(.N(N)) u_pick_idle (
        .vec_i   (w_elig),
        .start_i (w_start_idle),
        .found_o (w_idle_found),
        .idx_o   (w_idle_idx),
        .multi_o (w_idle_multi)
    );

    rr_pick #(.N(N)) u_pick_acc (
        .vec_i   (w_elig_acc),
        .start_i (w_start_acc),
        .found_o (w_acc_found),
        .idx_o   (w_acc_idx),
        .multi_o (w_acc_multi)
    );

    // Set wins over clear on a same-cycle collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_ptr     <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | req_i;
            if (w_accept) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_multi <= w_multi_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_idle_found)                w_state_nxt = ST_HOLD;
            ST_HOLD: if (w_accept && !w_acc_found)    w_state_nxt = ST_IDLE;
            default:                                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idx_nxt   = r_idx;
        w_multi_nxt = r_multi;
        case (r_state)
            ST_IDLE: begin
                if (w_idle_found) begin
                    w_idx_nxt   = w_idle_idx;
                    w_multi_nxt = w_idle_multi;
                end
            end
            ST_HOLD: begin
                if (w_accept && w_acc_found) begin
                    w_idx_nxt   = w_acc_idx;
                    w_multi_nxt = w_acc_multi;
                end
            end
            default: ;
        endcase
    end

    assign out_valid = (r_state == ST_HOLD);
    assign out_idx   = r_idx;
    assign out_multi = r_multi;
    assign pending_o = r_pending;

endmodule

// File: doc/req_priority_encoder.md
# req_priority_encoder

Registered, parametrised request encoder. It is the sequential successor to the team's combinational one-hot encoders. Single-cycle request pulses are captured into a pending register, and one eligible request at a time is encoded to a binary index on a valid/ready output. The arbitration mode is either fixed priority or round-robin. The block sits between interrupt and request sources and a single consumer, such as an interrupt controller or DMA channel dispatcher.

## Interface

Parameters:
- `N`, default 8: number of request lines, N ≥ 2. Non-power-of-2 values are legal.
- `RR_MODE`, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `W` (localparam): $clog2(N), the index width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_i`  in  N  request pulses or levels. A bit high at an edge sets the matching pending bit.
- `mask_i`  in  N  1 makes the bit ineligible for selection. A masked bit still latches into pending.
- `out_valid`  out  1  `out_idx` holds a selected request.
- `out_ready`  in  1  the consumer accepts when `out_valid` and `out_ready` are both high at an edge.
- `out_idx`  out  W  binary index of the selected request; always < N.
- `out_multi`  out  1  at selection time, at least one other eligible request was pending besides the selected one.
- `pending_o`  out  N  current pending register.

## Operation

- **Pending update:** pending <= (pending & ~clr) | req_i.
  - clr is onehot(out_idx) on an accept, otherwise 0.
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- **Eligible set:** pending & ~mask_i, taken from the registered pending value. `req_i` from the current cycle is never used.
- **Fixed mode:** select the lowest set index of the eligible set.
- **Round-robin mode:**
  - Search starts at pointer `ptr` and wraps N-1 → 0.
  - On every accept, ptr <= (out_idx == N-1) ? 0 : out_idx+1.
- **FSM states:**
  - IDLE: `out_valid`=0. If the eligible set is non-zero, register the selection into `out_idx`, set `out_multi`, and go to HOLD.
  - HOLD: `out_valid`=1. `out_idx` and `out_multi` stay stable until accept. A later mask or new request on the held index does not change or withdraw it.
  - HOLD, on accept: compute the next selection from eligible & ~onehot(out_idx), using the updated pointer in RR mode. If it is non-zero, stay in HOLD with the new index. Otherwise go to IDLE.
- **Reset values:** `out_valid`=0, `out_idx`=0, `out_multi`=0, `pending_o`=0, ptr=0, state IDLE. Reset asserted mid-HOLD drops `out_valid` immediately (asynchronously) and discards all pending requests.

## Timing

- **Latency:** a request sampled at edge k shows in `pending_o` after edge k. `out_valid` is asserted after edge k+1, so latency is 2 cycles from `req_i` to `out_valid`.
- **Throughput:** one accept per cycle when backlog exists, with no bubble between back-to-back grants.
- **Output registers:** all outputs are registered. No combinational path runs from `out_ready`, `req_i` or `mask_i` to any output.
- **Masking while idle:** fully masked pending requests leave the block in IDLE. Unmasking at edge k gives `out_valid` after edge k+1.

## Structure

- **Shared package `enc_pkg`:** state enum typedef (IDLE, HOLD) and the `onehot` helper function. The next encoder variants reuse both.
- **Sub-module `rr_pick`:** combinational. Inputs are an N-bit vector and a W-bit start pointer; outputs are found, index and multi. Fixed mode instantiates it with start = 0.
- **Instances:** two copies, one for the IDLE-path selection and one for the post-accept selection.

## Test plan

1. **Reset:** in HOLD with idx=2 and pending=8'h14, pull `rst_n` low between edges. Required: `out_valid`=0 at once; `out_idx`=0 and `pending_o`=0 while in reset. After release, no output until a new request.
2. **Fixed mode, N=8:** `req_i`=8'b1001_0100 for one cycle, `out_ready`=1. Required: idx 2, 4, 7 on three consecutive cycles; `out_multi` = 1, 1, 0; then IDLE.
3. **Backpressure:** hold idx=2 with `out_ready`=0 for 5 cycles, and pulse `req_i` bit 0 meanwhile. Required: idx stays 2 with `out_valid` stable. After ready, the next grant is 0.
4. **Round-robin, N=5:** `req_i`=5'h1F every cycle, `out_ready`=1. Required: idx 0, 1, 2, 3, 4, 0, 1 (pointer wrap at N-1).
5. **Mask:** `mask_i`=8'h0F, `req_i`=8'h11 pulse. Required: only idx 4 is granted and `pending_o`=8'h01 afterwards. Clearing the mask gives idx 0 two edges later.
6. **Set/clear collision:** pulse `req_i` bit 3 in the same cycle as the accept of idx 3. Required: bit 3 stays pending and is granted again next.
